probe_display_ctrl: RTL

//  Front-panel controller for the FPGA debug probe: drives the 7-bit one-hot probe select into the

---
 rtl/probe_display_pkg.sv | 43 ++++
 rtl/hex7seg.sv | 17 +
 rtl/probe_display_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/probe_display_pkg.sv
// ---------------------------------------------------------------------------
// probe_display_pkg
//   Shared constants for the debug-probe front panel:
//     - probe_e     : probe index codes (PROBE_PC .. PROBE_ALU, values 0..7)
//     - SEL_WIDTH   : width of the one-hot probe select bus
//     - NUM_DIGITS  : number of 7-segment digits on the board
//     - HEX_SEG_N   : hex digit -> active-low segment pattern {g,f,e,d,c,b,a}
//     - probe_sel() : probe index -> one-hot select (ALU view = all zero)
// ---------------------------------------------------------------------------
package probe_display_pkg;

    localparam int SEL_WIDTH  = 7;
    localparam int NUM_DIGITS = 8;
    localparam int IDX_WIDTH  = 3;

    typedef enum logic [IDX_WIDTH-1:0] {
        PROBE_PC        = 3'd0,
        PROBE_PCTARGET  = 3'd1,
        PROBE_RS1       = 3'd2,
        PROBE_RS2       = 3'd3,
        PROBE_RD        = 3'd4,
        PROBE_READDATA  = 3'd5,
        PROBE_WRITEDATA = 3'd6,
        PROBE_ALU       = 3'd7
    } probe_e;

    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX_SEG_N = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // The ALU result is the mux default, selected by driving no select line.
    function automatic logic [SEL_WIDTH-1:0] probe_sel(input probe_e idx);
        if (idx == PROBE_ALU) begin
            return '0;
        end
        return {{(SEL_WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex-digit to 7-segment decoder.
//   Ports:
//     digit  in  4  hex value to display
//     seg_n  out 7  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex7seg
    import probe_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG_N[digit];

endmodule

// File: rtl/probe_display_ctrl.sv
// ---------------------------------------------------------------------------
// probe_display_ctrl
//   Front-panel controller for the FPGA debug probe. A debounced push-button
//   steps a 3-bit probe index that drives the one-hot probe select; the
//   returned 32-bit probe word is scanned onto an 8-digit 7-segment display.
//
//   Optional feature: define DBG_AUTOSCAN_EN to make the index also advance
//   automatically every AUTO_DIV cycles.
//
//   Ports:
//     clk       in   1   system clock
//     rst       in   1   synchronous, active-high reset
//     btn_next  in   1   raw asynchronous push-button, active-high
//     x_in      in   32  probe word returned by the probe mux
//     sel_out   out  7   one-hot probe select (all-zero = ALU result)
//     seg_n     out  7   segments {g,f,e,d,c,b,a}, active-low
//     dp_n      out  1   decimal point, active-low
//     an_n      out  8   digit anodes, active-low one-hot, bit 0 = rightmost
//     led_sel   out  3   current probe index, binary
// ---------------------------------------------------------------------------
module probe_display_ctrl
    import probe_display_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES  = 20'd1_000_000,
    parameter logic [15:0] REFRESH_DIV = 16'd50_000,
    parameter logic [27:0] AUTO_DIV    = 28'd100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_next,
    input  logic [31:0]           x_in,
    output logic [SEL_WIDTH-1:0]  sel_out,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [IDX_WIDTH-1:0]  led_sel
);

    // Button synchronizer and debouncer
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic        deb_lvl_q, deb_lvl_d;
    logic        btn_step;
    logic        step;

    // Probe index and outputs to the mux / LEDs
    probe_e                idx_q, idx_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [IDX_WIDTH-1:0]  led_q, led_d;

    // Display capture and scan
    logic [31:0]           x_q, x_d;
    logic [15:0]           pre_cnt_q, pre_cnt_d;
    logic [2:0]            dig_q, dig_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg_n;

`ifdef DBG_AUTOSCAN_EN
    logic [27:0] auto_cnt_q, auto_cnt_d;
    logic        auto_tick;
`else
    logic        unused_auto_div;
    assign unused_auto_div = ^AUTO_DIV;
`endif

    assign cur_nibble = x_q[{dig_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .digit (cur_nibble),
        .seg_n (cur_seg_n)
    );

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        sync1_d   = btn_next;
        sync2_d   = sync1_q;
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;

        // The counter only runs while the synced input disagrees with the
        // accepted level; any agreement (a bounce back) restarts it.
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_CYCLES - 20'd1) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end

        btn_step = deb_lvl_d & ~deb_lvl_q;

`ifdef DBG_AUTOSCAN_EN
        auto_tick = (auto_cnt_q == AUTO_DIV - 28'd1);
        // A coincident button step and auto tick merge into one step, and a
        // button step also restarts the auto period.
        step       = btn_step | auto_tick;
        auto_cnt_d = step ? '0 : auto_cnt_q + 28'd1;
`else
        step = btn_step;
`endif

        idx_d = step ? probe_e'(idx_q + 3'd1) : idx_q;
        sel_d = probe_sel(idx_d);
        led_d = idx_d;

        // The probe mux is combinational, so the word always trails the
        // select by one cycle; it is shown as-is without blanking.
        x_d = x_in;

        pre_cnt_d = pre_cnt_q + 16'd1;
        dig_d     = dig_q;
        if (pre_cnt_q == REFRESH_DIV - 16'd1) begin
            pre_cnt_d = '0;
            dig_d     = dig_q + 3'd1;
        end

        // Anode, segments and dp all derive from the same dig_q so they
        // switch on the same edge.
        an_n_d  = ~(8'b1 << dig_q);
        seg_n_d = cur_seg_n;
        dp_n_d  = !((dig_q == 3'd7) && (idx_q == PROBE_ALU));
    end

    // NOTE: all state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            deb_lvl_q  <= 1'b0;
            idx_q      <= PROBE_PC;
            sel_q      <= probe_sel(PROBE_PC);
            led_q      <= '0;
            x_q        <= '0;
            pre_cnt_q  <= '0;
            dig_q      <= '0;
            an_n_q     <= 8'hFE;
            seg_n_q    <= SEG_BLANK_N;
            dp_n_q     <= 1'b1;
`ifdef DBG_AUTOSCAN_EN
            auto_cnt_q <= '0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
            x_q        <= x_d;
            pre_cnt_q  <= pre_cnt_d;
            dig_q      <= dig_d;
            an_n_q     <= an_n_d;
            seg_n_q    <= seg_n_d;
            dp_n_q     <= dp_n_d;
`ifdef DBG_AUTOSCAN_EN
            auto_cnt_q <= auto_cnt_d;
`endif
        end
    end

    assign sel_out = sel_q;
    assign led_sel = led_q;
    assign an_n    = an_n_q;
    assign seg_n   = seg_n_q;
    assign dp_n    = dp_n_q;

endmodule
